// File: rtl/gs_dac_mixer.sv
// Multi-channel 1-bit DAC mixer. Each channel holds an unsigned sample and a
// volume. The sample drives one of two modulators: a gated first-order
// accumulator enabled by a PWM volume gate (mode 0), or a first-order
// accumulator fed by the sample*volume product (mode 1). Samples may be
// written straight into the active register or double-buffered until a
// frame strobe commits them all together.
module gs_dac_mixer #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 8,
    parameter int VOL_W    = 6,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk32,
    input  logic                rst_n,
    input  logic                smp_we,
    input  logic [CW-1:0]       smp_ch,
    input  logic [DATA_W-1:0]   smp_d,
    input  logic                vol_we,
    input  logic [CW-1:0]       vol_ch,
    input  logic [VOL_W-1:0]    vol_d,
    input  logic                mode,
    input  logic                sync_en,
    input  logic                frame,
    input  logic                ovr_clr,
    output logic [CHANNELS-1:0] dac_out,
    output logic                smp_ovr
);

    localparam int PW = DATA_W + VOL_W;   // product width
    localparam int AW = PW + 1;           // accumulator width (mode 1 uses all of it)

    // Odd step, so the volume counter visits every value once per 2^VOL_W cycles
    // in a scattered order, which spreads the gate-on cycles evenly.
    localparam logic [VOL_W-1:0] VOL_STEP = VOL_W'((2 ** (VOL_W - 1)) - 1);

    logic [DATA_W-1:0]   active_q  [CHANNELS];
    logic [DATA_W-1:0]   active_d  [CHANNELS];
    logic [DATA_W-1:0]   shadow_q  [CHANNELS];
    logic [DATA_W-1:0]   shadow_d  [CHANNELS];
    logic [VOL_W-1:0]    vol_lvl_q [CHANNELS];
    logic [VOL_W-1:0]    vol_lvl_d [CHANNELS];
    logic [PW-1:0]       prod_q    [CHANNELS];
    logic [PW-1:0]       prod_d    [CHANNELS];
    logic [AW-1:0]       acc_q     [CHANNELS];
    logic [AW-1:0]       acc_d     [CHANNELS];

    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] vol_en_q,  vol_en_d;
    logic [CHANNELS-1:0] dac_q,     dac_d;
    logic [VOL_W-1:0]    vol_cnt_q, vol_cnt_d;
    logic                smp_ovr_q, smp_ovr_d;
    logic                mode_q, mode_prev_q;

    logic                commit;
    logic                ovr_set;
    logic                mode_chg;

    // Sample path: commit pending shadows, then apply this cycle's write.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        commit    = frame | (~sync_en & (|pending_q));
        ovr_set   = 1'b0;
        pending_d = pending_q;
        for (int i = 0; i < CHANNELS; i++) begin
            active_d[i] = active_q[i];
            shadow_d[i] = shadow_q[i];
        end
        for (int i = 0; i < CHANNELS; i++) begin
            // The commit sees the old shadow, so a same-cycle write cannot leak in.
            if (commit && pending_q[i]) begin
                active_d[i]  = shadow_q[i];
                pending_d[i] = 1'b0;
            end
            // Indices at or above CHANNELS match no i and are dropped.
            if (smp_we && (smp_ch == CW'(i))) begin
                if (sync_en) begin
                    shadow_d[i]  = smp_d;
                    pending_d[i] = 1'b1;
                    if (pending_q[i] && !commit) begin
                        ovr_set = 1'b1;
                    end
                end else begin
                    active_d[i] = smp_d;
                end
            end
        end
        // A fresh overrun outranks a clear in the same cycle.
        smp_ovr_d = ovr_set | (smp_ovr_q & ~ovr_clr);
    end

    // Volume register file.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            vol_lvl_d[i] = vol_lvl_q[i];
            if (vol_we && (vol_ch == CW'(i))) begin
                vol_lvl_d[i] = vol_d;
            end
        end
    end

    // Modulators: volume gate, product, accumulators and the output bits.
    always_comb begin
        mode_chg  = mode_q ^ mode_prev_q;
        vol_cnt_d = vol_cnt_q + VOL_STEP;
        for (int i = 0; i < CHANNELS; i++) begin
            vol_en_d[i] = (vol_cnt_q < vol_lvl_q[i]);
            prod_d[i]   = PW'(active_q[i]) * PW'(vol_lvl_q[i]);
            if (mode_q) begin
                acc_d[i] = {1'b0, acc_q[i][AW-2:0]} + {1'b0, prod_q[i]};
            end else if (vol_en_q[i]) begin
                acc_d[i] = AW'({1'b0, acc_q[i][DATA_W-1:0]} + {1'b0, active_q[i]});
            end else begin
                acc_d[i] = AW'({1'b0, acc_q[i][DATA_W-1:0]});
            end
            // Restart both modulators cleanly after a mode switch.
            if (mode_chg) begin
                acc_d[i]  = '0;
                prod_d[i] = '0;
            end
            // The output flop tracks the accumulator carry bit of the current mode.
            dac_d[i] = mode_q ? acc_d[i][AW-1] : acc_d[i][DATA_W];
        end
    end

    // State registers.
    // NOTE: the per-channel arrays are reset explicitly because a reset must
    // silence every output and discard pending samples, not just the control.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_q[i]  <= '0;
                shadow_q[i]  <= '0;
                vol_lvl_q[i] <= '0;
                prod_q[i]    <= '0;
                acc_q[i]     <= '0;
            end
            pending_q   <= '0;
            vol_en_q    <= '0;
            dac_q       <= '0;
            vol_cnt_q   <= '0;
            smp_ovr_q   <= 1'b0;
            mode_q      <= 1'b0;
            mode_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            for (int i = 0; i < CHANNELS; i++) begin
                active_q[i]  <= active_d[i];
                shadow_q[i]  <= shadow_d[i];
                vol_lvl_q[i] <= vol_lvl_d[i];
                prod_q[i]    <= prod_d[i];
                acc_q[i]     <= acc_d[i];
            end
            pending_q   <= pending_d;
            vol_en_q    <= vol_en_d;
            dac_q       <= dac_d;
            vol_cnt_q   <= vol_cnt_d;
            smp_ovr_q   <= smp_ovr_d;
            mode_q      <= mode;
            mode_prev_q <= mode_q;
        end
    end

    assign dac_out = dac_q;
    assign smp_ovr = smp_ovr_q;

endmodule

// File: doc/gs_dac_mixer.md
GS_DAC_MIXER -- requirements
Module: gs_dac_mixer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of DAC channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 8, sample width.
REQ-003 SHALL have parameter VOL_W, default 6, volume width.
REQ-004 SHALL have port clk32  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port smp_we  in  1  sample write strobe, one cycle per write.
REQ-007 SHALL have port smp_ch  in  CW  sample channel index, CW = max(1, clog2(CHANNELS)).
REQ-008 SHALL have port smp_d  in  DATA_W  unsigned sample.
REQ-009 SHALL have port vol_we  in  1  volume write strobe.
REQ-010 SHALL have port vol_ch  in  CW  volume channel index.
REQ-011 SHALL have port vol_d  in  VOL_W  unsigned volume.
REQ-012 SHALL have port mode  in  1  0 = gated modulator, 1 = scaled modulator.
REQ-013 SHALL have port sync_en  in  1  1 = samples double-buffered until frame.
REQ-014 SHALL have port frame  in  1  commit strobe for pending samples.
REQ-015 SHALL have port ovr_clr  in  1  clears smp_ovr.
REQ-016 SHALL have port dac_out  out  CHANNELS  1-bit modulator outputs, registered.
REQ-017 SHALL have port smp_ovr  out  1  sticky overrun flag, registered.

Function
REQ-018 smp_we, vol_we SHALL be ignored when their index >= CHANNELS.
REQ-019 vol_we SHALL update vol[ch] on the next edge.
REQ-020 With sync_en=0, smp_we SHALL update active[ch] on the next edge.
REQ-021 With sync_en=1, smp_we SHALL write shadow[ch] and set pending[ch]; active[ch] SHALL be unchanged.
REQ-022 frame=1, or sync_en=0 with any pending bit set, SHALL copy every pending shadow to active and clear those pending bits in one edge.
REQ-023 smp_we and commit in the same cycle SHALL commit the old shadow first; the new write then lands in shadow with pending=1.
REQ-024 smp_we to a channel with pending=1 and no commit that cycle SHALL set smp_ovr; the shadow is overwritten.
REQ-025 ovr_clr SHALL clear smp_ovr; a simultaneous overrun SHALL win, leaving smp_ovr=1.
REQ-026 vol_cnt (VOL_W bits) SHALL advance by 2^(VOL_W-1)-1 every cycle, modulo 2^VOL_W.
REQ-027 vol_en[i] SHALL be registered as (vol_cnt < vol[i]) unsigned, one cycle of latency.
REQ-028 Mode 0, vol_en[i]=1: acc[i] (DATA_W+1 bits) <= acc[i][DATA_W-1:0] + active[i].
REQ-029 Mode 0, vol_en[i]=0: acc[i] MSB <= 0, low bits hold.
REQ-030 Mode 0 output: dac_out[i] = acc[i][DATA_W].
REQ-031 Mode 1: prod[i] <= active[i]*vol[i], registered, DATA_W+VOL_W bits.
REQ-032 Mode 1: acc[i] (DATA_W+VOL_W+1 bits) <= acc[i] low bits + prod[i] every cycle.
REQ-033 Mode 1 output: dac_out[i] = acc[i] MSB.
REQ-034 The mode input SHALL be registered; any change of the registered mode SHALL clear all acc and prod on the following edge.
REQ-035 Latency, active update to first dac_out effect: mode 0 = 2 cycles; mode 1 = 3 cycles.
REQ-036 vol=0 SHALL force dac_out[i]=0 in both modes, from 2 cycles after the write.

Reset
REQ-037 rst_n=0 SHALL asynchronously clear active, shadow, pending, vol, vol_cnt, vol_en, acc, prod, registered mode, dac_out and smp_ovr to 0.
REQ-038 Reset mid-frame SHALL discard pending shadows; no commit occurs after release.

Verification
REQ-039 Reset: assert rst_n=0 mid-activity -> dac_out=0 and smp_ovr=0 immediately, before any clock edge.
REQ-040 Mode 0, defaults, vol[0]=63, active[0]=0x80 -> dac_out[0] high for 8064±2 of 16384 cycles; vol[0]=0 -> 0 highs.
REQ-041 sync_en=1, write ch1=0xFF, vol[1]=63, no frame -> dac_out[1] stays 0; pulse frame -> first high no later than 3 cycles after the frame.
REQ-042 sync_en=1, two writes to ch2 without frame -> smp_ovr=1; repeat with frame coincident with the second write -> smp_ovr stays 0.
REQ-043 smp_ovr=1, ovr_clr and an overrunning smp_we in the same cycle -> smp_ovr=1; ovr_clr alone -> 0.
REQ-044 Mode 1, active[3]=0xFF, vol[3]=32 -> dac_out[3] high for 8160±2 of 16384 cycles; toggle mode -> all acc read 0 on the next cycle.
